// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding, line levels and data-bit counts.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    localparam int UART_BITS_7 = 7;
    localparam int UART_BITS_8 = 8;

    // Index of the last data bit for the captured character length.
    function automatic logic [3:0] last_bit_idx(input logic bit8);
        return bit8 ? 4'(UART_BITS_8 - 1) : 4'(UART_BITS_7 - 1);
    endfunction

endpackage

// File: rtl/uart_tx_hold_reg.sv
// One-entry transmit holding register: accepts a byte on valid/ready, releases it on load.
module uart_tx_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              load,
    output logic              hold_valid,
    output logic [DATA_W-1:0] hold_data
);

    logic accept;

    assign wr_ready = ~hold_valid;
    assign accept   = wr_valid & ~hold_valid;

    // Load is only requested while full and a write only lands while empty, so they never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            if (load) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
            end
            if (accept) begin
                hold_data <= wr_data;
            end
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 7/8 data bits LSB first, optional parity, 1/2 stop bits.
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter bit STOP2_DEFAULT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              xmit_pulse,
    input  logic              bit8,
    input  logic              stop2,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_en,
    input  logic              parity_odd,
`endif
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              cfg_bit8_q, cfg_bit8_d;
    logic              cfg_stop2_q, cfg_stop2_d;
    logic              tx_q, tx_d;
    logic              load;
    logic              done;
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;
`ifdef UART_TX_PARITY_EN
    logic              cfg_par_en_q, cfg_par_en_d;
    logic              par_q, par_d;
`endif

    uart_tx_hold_reg #(
        .DATA_W(DATA_W)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (tx_valid),
        .wr_data   (tx_data),
        .wr_ready  (tx_ready),
        .load      (load),
        .hold_valid(hold_valid),
        .hold_data (hold_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= TX_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            cfg_bit8_q   <= 1'b1;
            cfg_stop2_q  <= STOP2_DEFAULT;
            tx_q         <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            cfg_par_en_q <= 1'b0;
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            cfg_bit8_q   <= cfg_bit8_d;
            cfg_stop2_q  <= cfg_stop2_d;
            tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
            cfg_par_en_q <= cfg_par_en_d;
            par_q        <= par_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        cfg_bit8_d   = cfg_bit8_q;
        cfg_stop2_d  = cfg_stop2_q;
        tx_d         = tx_q;
        load         = 1'b0;
        done         = 1'b0;
`ifdef UART_TX_PARITY_EN
        cfg_par_en_d = cfg_par_en_q;
        par_d        = par_q;
`endif
        if (xmit_pulse) begin
            case (state_q)
                TX_IDLE: begin
                    if (hold_valid) begin
                        load    = 1'b1;
                        state_d = TX_START;
                        tx_d    = UART_START_LEVEL;
                    end
                end
                TX_START: begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_d     = par_q ^ shift_q[0];
`endif
                    state_d   = TX_DATA;
                end
                TX_DATA: begin
                    if (bit_cnt_q == last_bit_idx(cfg_bit8_q)) begin
                        stop_cnt_d = 1'b0;
                        state_d    = TX_STOP;
                        tx_d       = UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
                        if (cfg_par_en_q) begin
                            state_d = TX_PARITY;
                            tx_d    = par_q;
                        end
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef UART_TX_PARITY_EN
                        par_d     = par_q ^ shift_q[0];
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    stop_cnt_d = 1'b0;
                    state_d    = TX_STOP;
                    tx_d       = UART_IDLE_LEVEL;
                end
`endif
                TX_STOP: begin
                    if (cfg_stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        done = 1'b1;
                        // A waiting byte starts immediately so back-to-back frames have no idle gap.
                        if (hold_valid) begin
                            load    = 1'b1;
                            state_d = TX_START;
                            tx_d    = UART_START_LEVEL;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = TX_IDLE;
                    tx_d    = UART_IDLE_LEVEL;
                end
            endcase
        end

        // Frame configuration is frozen at load so mid-frame changes take effect next frame.
        if (load) begin
            shift_d      = hold_data;
            cfg_bit8_d   = bit8;
            cfg_stop2_d  = stop2;
`ifdef UART_TX_PARITY_EN
            cfg_par_en_d = parity_en;
            par_d        = parity_odd;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != TX_IDLE);
    assign tx_done = done;

endmodule
